// File: rtl/crono_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD digit limits,
// the zero time and the preset validity check.
package crono_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } crono_state_t;

   localparam logic [3:0]  TENS_MAX_MS = 4'd5;
   localparam logic [3:0]  UNITS_MAX   = 4'd9;
   localparam logic [3:0]  TENS_MAX_H  = 4'd2;
   localparam logic [7:0]  HOURS_MAX   = 8'h23;
   localparam logic [23:0] ZERO_TIME   = 24'h00_00_00;

   // Valid BCD digits compare correctly as plain hex, so hours <= 8'h23 works
   // once every digit is known to be in range.
   function automatic logic preset_ok(input logic [23:0] t);
      logic digits_ok;
      digits_ok = (t[23:20] <= TENS_MAX_H)  && (t[19:16] <= UNITS_MAX) &&
                  (t[23:16] <= HOURS_MAX)   &&
                  (t[15:12] <= TENS_MAX_MS) && (t[11:8]  <= UNITS_MAX) &&
                  (t[7:4]   <= TENS_MAX_MS) && (t[3:0]   <= UNITS_MAX);
      return digits_ok && (t != ZERO_TIME);
   endfunction

endpackage

// File: rtl/crono_bcd_dec.sv
// Combinational HH:MM:SS BCD decrement by one second, saturating at 00:00:00,
// with a flag that the decremented value is zero.
module crono_bcd_dec
   import crono_pkg::*;
(
   input  logic [23:0] t_in,
   output logic [23:0] t_dec,
   output logic        is_zero
);

   // Returns {borrow_out, new_digit}; a digit only moves when borrowed from.
   function automatic logic [4:0] dig_dec(input logic [3:0] d,
                                          input logic [3:0] wrap,
                                          input logic       b_in);
      if (!b_in)
         return {1'b0, d};
      else if (d == 4'd0)
         return {1'b1, wrap};
      else
         return {1'b0, d - 4'd1};
   endfunction

   logic [4:0] su_r, st_r, mu_r, mt_r, hu_r;
   logic [3:0] ht_n;

   always_comb begin
      su_r  = dig_dec(t_in[3:0],   UNITS_MAX,   1'b1);
      st_r  = dig_dec(t_in[7:4],   TENS_MAX_MS, su_r[4]);
      mu_r  = dig_dec(t_in[11:8],  UNITS_MAX,   st_r[4]);
      mt_r  = dig_dec(t_in[15:12], TENS_MAX_MS, mu_r[4]);
      hu_r  = dig_dec(t_in[19:16], UNITS_MAX,   mt_r[4]);
      ht_n  = hu_r[4] ? (t_in[23:20] - 4'd1) : t_in[23:20];
      t_dec = {ht_n, hu_r[3:0], mt_r[3:0], mu_r[3:0], st_r[3:0], su_r[3:0]};
      // Hour tens can only borrow from a zero count, which must stay at zero.
      if (t_in == ZERO_TIME)
         t_dec = ZERO_TIME;
      is_zero = (t_dec == ZERO_TIME);
   end

endmodule

// File: rtl/crono_control.sv
// Countdown timer controller: button edge detect, IDLE/RUN/PAUSE/DONE FSM and
// BCD countdown register. Define CRONO_ALARM_BLINK_EN to make alarm toggle per tick in DONE.
module crono_control
   import crono_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       tick_1hz,
   input  logic [7:0] preset_h,
   input  logic [7:0] preset_m,
   input  logic [7:0] preset_s,
   output logic [7:0] cnt_h,
   output logic [7:0] cnt_m,
   output logic [7:0] cnt_s,
   output logic       edit_en,
   output logic       running,
   output logic       alarm,
   output logic [1:0] state
);

   crono_state_t state_q, state_d;
   logic [23:0]  cnt_q, cnt_d, cnt_dec;
   logic [23:0]  preset;
   logic         dec_zero;
   logic         alarm_q, alarm_d;
   logic         start_q, stop_q;
   logic         start_edge, stop_edge;

   assign preset     = {preset_h, preset_m, preset_s};
   assign start_edge = start & ~start_q;
   assign stop_edge  = stop & ~stop_q;

   crono_bcd_dec u_dec (
      .t_in    (cnt_q),
      .t_dec   (cnt_dec),
      .is_zero (dec_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= ZERO_TIME;
         alarm_q <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
         start_q <= start;
         stop_q  <= stop;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = preset;
            // A simultaneous stop edge wins, and stop has nothing to do in IDLE.
            if (start_edge && !stop_edge && preset_ok(preset))
               state_d = RUN;
         end
         RUN: begin
            // The tick lands first; reaching zero overrides a same-cycle stop.
            if (tick_1hz) begin
               cnt_d = cnt_dec;
               if (dec_zero) begin
                  state_d = DONE;
                  alarm_d = 1'b1;
               end else if (stop_edge) begin
                  state_d = PAUSE;
               end
            end else if (stop_edge) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (stop_edge)
               state_d = IDLE;
            else if (start_edge)
               state_d = RUN;
         end
         DONE: begin
            if (start_edge || stop_edge) begin
               state_d = IDLE;
               alarm_d = 1'b0;
            end else if (tick_1hz) begin
`ifdef CRONO_ALARM_BLINK_EN
               alarm_d = ~alarm_q;
`else
               alarm_d = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            alarm_d = 1'b0;
         end
      endcase
   end

   assign cnt_h   = cnt_q[23:16];
   assign cnt_m   = cnt_q[15:8];
   assign cnt_s   = cnt_q[7:0];
   assign state   = state_q;
   assign edit_en = (state_q == IDLE);
   assign running = (state_q == RUN);
   assign alarm   = alarm_q;

endmodule
